// File: rtl/cache_pkg.sv
// Shared types and sizing for the 4-way, 2048-set cache control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int CACHE_WAYS = 4;
    localparam int SET_BITS   = 11;
    localparam int TAG_BITS   = 14;

    // Way-select controller states
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        FILL_WAIT,
        UPDATE
    } state_t;

    // One way's tag RAM entry as stored in tag_rd_data, valid in the MSB
    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/cache_tag_compare.sv
// Per-way tag compare and victim choice for one looked-up set.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever tag_rd_data is valid.
module cache_tag_compare
    import cache_pkg::*;
#(
    parameter int TAG_W = cache_pkg::TAG_BITS
) (
    input  logic [CACHE_WAYS*(TAG_W+1)-1:0] tag_rd_data,
    input  logic [TAG_W-1:0]                req_tag,
    input  logic [1:0]                      lru_least_used,
    output logic                            hit,
    output logic [1:0]                      hit_way,
    output logic [1:0]                      victim_way
);

    logic [CACHE_WAYS-1:0] way_valid;
    logic [CACHE_WAYS-1:0] way_match;

    // Unpack each {valid,tag} entry and compare against the request tag
    always_comb begin
        way_valid = '0;
        way_match = '0;
        for (int w = 0; w < CACHE_WAYS; w++) begin
            way_valid[w] = tag_rd_data[w*(TAG_W+1) + TAG_W];
            way_match[w] = way_valid[w] &&
                           (tag_rd_data[w*(TAG_W+1) +: TAG_W] == req_tag);
        end
    end

    // Lowest index wins for both a (illegal) multi-hit and the invalid-way search;
    // only a completely valid set falls back to the LRU way
    always_comb begin
        hit        = |way_match;
        hit_way    = 2'd0;
        victim_way = lru_least_used;
        for (int w = CACHE_WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) hit_way = 2'(w);
            if (!way_valid[w]) victim_way = 2'(w);
        end
    end

endmodule

// File: rtl/cache_way_select.sv
// Lookup control ahead of cache_LRU: hit/miss resolve, fill sequencing, tag write, LRU used update.
// Latency: hit accept C0 -> resp C2; miss resp one cycle after the tag write (fill_done) cycle.
// Backpressure: req_ready only in IDLE; fill request held stable until fill_req_ready.
module cache_way_select #(
    parameter int SET_BITS = cache_pkg::SET_BITS,
    parameter int TAG_BITS = cache_pkg::TAG_BITS
) (
    input  logic                         main_clk,
    input  logic                         main_reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [TAG_BITS+SET_BITS-1:0] req_addr,
    output logic                         tag_rd_en,
    output logic [SET_BITS-1:0]          tag_rd_set,
    input  logic [4*(TAG_BITS+1)-1:0]    tag_rd_data,
    output logic                         tag_wr_en,
    output logic [SET_BITS-1:0]          tag_wr_set,
    output logic [1:0]                   tag_wr_way,
    output logic [TAG_BITS-1:0]          tag_wr_tag,
    output logic [SET_BITS-1:0]          lru_addr,
    output logic [1:0]                   lru_used_index,
    output logic                         lru_enable_write,
    input  logic [1:0]                   lru_least_used,
    output logic                         fill_req_valid,
    input  logic                         fill_req_ready,
    output logic [TAG_BITS+SET_BITS-1:0] fill_addr,
    output logic [1:0]                   fill_way,
    input  logic                         fill_done,
    output logic                         resp_valid,
    output logic                         resp_hit,
    output logic [1:0]                   resp_way,
    output logic [SET_BITS-1:0]          resp_set
);

    import cache_pkg::state_t;
    import cache_pkg::IDLE;
    import cache_pkg::LOOKUP;
    import cache_pkg::FILL;
    import cache_pkg::FILL_WAIT;
    import cache_pkg::UPDATE;

    localparam int ADDR_BITS = TAG_BITS + SET_BITS;

    state_t               state;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 accept;
    logic                 cmp_hit;
    logic [1:0]           cmp_hit_way;
    logic [1:0]           cmp_victim_way;

    // The tag RAM and cache_LRU both need the set in the acceptance cycle so their
    // data lands in LOOKUP; outside that cycle the read address holds the latched set.
    assign accept     = (state == IDLE) && req_valid;
    assign req_ready  = (state == IDLE);
    assign tag_rd_en  = accept;
    assign tag_rd_set = accept ? req_addr[SET_BITS-1:0] : addr_q[SET_BITS-1:0];
    assign lru_addr   = accept ? req_addr[SET_BITS-1:0] : addr_q[SET_BITS-1:0];

    // The fill_done cycle itself is the tag write cycle, so UPDATE follows it directly.
    // Reads only occur in IDLE, so a tag read and write never coincide.
    assign tag_wr_en  = (state == FILL_WAIT) && fill_done;

    cache_tag_compare #(
        .TAG_W (TAG_BITS)
    ) u_tag_compare (
        .tag_rd_data    (tag_rd_data),
        .req_tag        (addr_q[ADDR_BITS-1:SET_BITS]),
        .lru_least_used (lru_least_used),
        .hit            (cmp_hit),
        .hit_way        (cmp_hit_way),
        .victim_way     (cmp_victim_way)
    );

    // Control FSM with registered fill, tag-write, LRU-update and response outputs
    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state            <= IDLE;
            addr_q           <= '0;
            tag_wr_set       <= '0;
            tag_wr_way       <= '0;
            tag_wr_tag       <= '0;
            lru_used_index   <= '0;
            lru_enable_write <= 1'b0;
            fill_req_valid   <= 1'b0;
            fill_addr        <= '0;
            fill_way         <= '0;
            resp_valid       <= 1'b0;
            resp_hit         <= 1'b0;
            resp_way         <= '0;
            resp_set         <= '0;
        end else begin
            lru_enable_write <= 1'b0;
            resp_valid       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cmp_hit) begin
                        lru_used_index   <= cmp_hit_way;
                        lru_enable_write <= 1'b1;
                        resp_valid       <= 1'b1;
                        resp_hit         <= 1'b1;
                        resp_way         <= cmp_hit_way;
                        resp_set         <= addr_q[SET_BITS-1:0];
                        state            <= UPDATE;
                    end else begin
                        // Tag write fields are captured now so they are stable by fill_done
                        fill_req_valid <= 1'b1;
                        fill_addr      <= addr_q;
                        fill_way       <= cmp_victim_way;
                        tag_wr_set     <= addr_q[SET_BITS-1:0];
                        tag_wr_way     <= cmp_victim_way;
                        tag_wr_tag     <= addr_q[ADDR_BITS-1:SET_BITS];
                        state          <= FILL;
                    end
                end
                FILL: begin
                    if (fill_req_ready) begin
                        fill_req_valid <= 1'b0;
                        state          <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (fill_done) begin
                        lru_used_index   <= tag_wr_way;
                        lru_enable_write <= 1'b1;
                        resp_valid       <= 1'b1;
                        resp_hit         <= 1'b0;
                        resp_way         <= tag_wr_way;
                        resp_set         <= tag_wr_set;
                        state            <= UPDATE;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
